// File: rtl/tl_ul_sram_slave_if.sv
// TileLink-UL A/D channel bundle for the 32-bit SRAM slave port.
//   A channel: a_valid/a_ready handshake, a_opcode, a_size, a_source,
//              a_address, a_mask, a_data
//   D channel: d_valid/d_ready handshake, d_opcode, d_size, d_source,
//              d_denied, d_data
// master drives A and d_ready; slave drives a_ready and the D payload.
interface tl_ul_sram_slave_if #(
  parameter int unsigned SRC_BITS = 4
) ();
  logic                a_valid;
  logic                a_ready;
  logic [2:0]          a_opcode;
  logic [2:0]          a_size;
  logic [SRC_BITS-1:0] a_source;
  logic [31:0]         a_address;
  logic [3:0]          a_mask;
  logic [31:0]         a_data;

  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [2:0]          d_size;
  logic [SRC_BITS-1:0] d_source;
  logic                d_denied;
  logic [31:0]         d_data;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_source, d_denied, d_data,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_size, d_source, d_denied, d_data,
    input  d_ready
  );
endinterface

// File: rtl/tl_ul_sram_slave.sv
// TileLink-UL slave terminating a 32-bit port onto a synchronous SRAM with
// one cycle of read latency. Get/PutFullData/PutPartialData become single
// SRAM accesses; illegal requests are answered denied without touching SRAM.
// Responses flow through a RSP_DEPTH-entry FIFO presented on the D channel.
// Ports:
//   clock, reset_n  rising-edge clock, synchronous active-low reset
//   tl              A/D channel bundle (slave modport)
//   mem_en/mem_we   SRAM access strobe / write select
//   mem_addr        SRAM word address (ADDR_BITS-2 bits)
//   mem_wmask       byte write enables
//   mem_wdata       write data
//   mem_rdata       read data, valid the cycle after a read strobe
module tl_ul_sram_slave #(
  parameter logic [31:0] ADDR_BASE = 32'h0800_0000,
  parameter int unsigned ADDR_BITS = 14,
  parameter int unsigned SRC_BITS  = 4,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  tl_ul_sram_slave_if.slave    tl,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-3:0] mem_addr,
  output logic [3:0]           mem_wmask,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(RSP_DEPTH + 1);

  typedef enum logic [2:0] {
    OP_PUT_FULL    = 3'd0,
    OP_PUT_PARTIAL = 3'd1,
    OP_GET         = 3'd4
  } a_op_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } d_op_e;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          size;
    logic [SRC_BITS-1:0] source;
    logic                denied;
    logic [31:0]         data;
  } rsp_t;

  // Stage 0 decode
  logic        is_get, is_put, size_ok, align_ok, range_ok, legal, fire;
  logic [31:0] offset;
  logic        a_ready_i, d_valid_i, deq;
  logic [OCC_W:0] pending;

  // Stage 1 and response queue
  logic                s1_valid, s1_is_get, s1_denied;
  logic [2:0]          s1_size;
  logic [SRC_BITS-1:0] s1_source;
  rsp_t                enq_entry, head;
  rsp_t                rsp_q [RSP_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [OCC_W-1:0]    occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    is_get   = (tl.a_opcode == OP_GET);
    is_put   = (tl.a_opcode == OP_PUT_FULL) || (tl.a_opcode == OP_PUT_PARTIAL);
    size_ok  = (tl.a_size <= 3'd2);
    align_ok = 1'b1;
    case (tl.a_size)
      3'd1:    align_ok = ~tl.a_address[0];
      3'd2:    align_ok = (tl.a_address[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    offset   = tl.a_address - ADDR_BASE;
    // 33-bit compare so a region ending at the top of the address map works
    range_ok = (tl.a_address >= ADDR_BASE) && ({1'b0, offset} < (33'd1 << ADDR_BITS));
    legal    = (is_get | is_put) & size_ok & align_ok & range_ok;
  end

  // Credit: count the response already in stage 1 so its enqueue always fits,
  // while a same-cycle dequeue frees a slot even when the queue is full.
  always_comb begin
    d_valid_i = reset_n & (occ != '0);
    deq       = d_valid_i & tl.d_ready;
    pending   = {1'b0, occ} + (OCC_W+1)'(s1_valid) - (OCC_W+1)'(deq);
    a_ready_i = reset_n & (pending < (OCC_W+1)'(RSP_DEPTH));
    fire      = tl.a_valid & a_ready_i;
    tl.a_ready = a_ready_i;
  end

  always_comb begin
    mem_en    = fire & legal;
    mem_we    = ~is_get;
    mem_addr  = (ADDR_BITS-2)'(offset >> 2);
    mem_wmask = is_get ? '0 : tl.a_mask;
    mem_wdata = tl.a_data;
  end

  always_ff @(posedge clock) begin
    if (fire) begin
      s1_is_get <= is_get;
      s1_denied <= ~legal;
      s1_size   <= tl.a_size;
      s1_source <= tl.a_source;
    end
  end

  always_comb begin
    enq_entry.opcode = s1_is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
    enq_entry.size   = s1_size;
    enq_entry.source = s1_source;
    enq_entry.denied = s1_denied;
    enq_entry.data   = (s1_is_get & ~s1_denied) ? mem_rdata : '0;
  end

  always_ff @(posedge clock) begin
    if (s1_valid) rsp_q[wr_ptr] <= enq_entry;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      s1_valid <= fire;
      if (s1_valid) wr_ptr <= ptr_inc(wr_ptr);
      if (deq)      rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + OCC_W'(s1_valid) - OCC_W'(deq);
    end
  end

  always_comb begin
    head        = rsp_q[rd_ptr];
    tl.d_valid  = d_valid_i;
    tl.d_opcode = d_valid_i ? head.opcode : '0;
    tl.d_size   = d_valid_i ? head.size   : '0;
    tl.d_source = d_valid_i ? head.source : '0;
    tl.d_denied = d_valid_i ? head.denied : 1'b0;
    tl.d_data   = d_valid_i ? head.data   : '0;
  end

endmodule

// File: tb/tb_tl_ul_sram_slave.sv
module tb_tl_ul_sram_slave;
  localparam logic [31:0] BASE  = 32'h0800_0000;
  localparam int unsigned AB    = 14;
  localparam int unsigned SB    = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned WORDS = 1 << (AB - 2);

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [3:0]  src;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [3:0]  src;
    logic        denied;
    logic [31:0] data;
  } rsp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  tl_ul_sram_slave_if #(.SRC_BITS(SB)) tl ();

  logic          mem_en, mem_we;
  logic [AB-3:0] mem_addr;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  tl_ul_sram_slave #(
    .ADDR_BASE(BASE), .ADDR_BITS(AB), .SRC_BITS(SB), .RSP_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n), .tl(tl),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural SRAM and an independent reference memory
  logic [31:0] sram [WORDS];
  logic [31:0] mdl  [WORDS];

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) sram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;
  int   n_beats  = 0;
  req_t req_q[$];
  rsp_t exp_q[$];
  logic s_a_ready, s_d_valid, s_mem_en, s_fire;
  logic [31:0] last_d_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic legal_f(input req_t r);
    logic op_ok, sz_ok, al_ok, rg_ok;
    op_ok = (r.op == 3'd0) || (r.op == 3'd1) || (r.op == 3'd4);
    sz_ok = (r.size <= 3'd2);
    al_ok = sz_ok && ((r.addr % (32'd1 << r.size)) == 0);
    rg_ok = (r.addr >= BASE) && ((r.addr - BASE) < (32'd1 << AB));
    return op_ok && sz_ok && al_ok && rg_ok;
  endfunction

  // Called at the sampling point of a cycle in which A fires
  task automatic accept(input req_t r);
    logic leg;
    int   w;
    rsp_t e;
    leg = legal_f(r);
    w = 0;
    if (leg) w = int'((r.addr - BASE) >> 2);
    check("mem_en", mem_en, leg);
    if (leg) begin
      check("mem_addr", mem_addr, w);
      check("mem_we", mem_we, r.op != 3'd4);
    end
    e.op     = (r.op == 3'd4) ? 3'd1 : 3'd0;
    e.size   = r.size;
    e.src    = r.src;
    e.denied = !leg;
    e.data   = (leg && r.op == 3'd4) ? mdl[w] : 32'h0;
    if (leg && r.op != 3'd4)
      for (int b = 0; b < 4; b++)
        if (r.mask[b]) mdl[w][8*b +: 8] = r.data[8*b +: 8];
    exp_q.push_back(e);
  endtask

  task automatic push_req(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                          input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    req_t r;
    r.op = op; r.size = size; r.src = src; r.addr = addr; r.mask = mask; r.data = data;
    req_q.push_back(r);
  endtask

  // One clock: present the head request, sample at negedge, return 1 after posedge
  task automatic drive_cycle();
    if (req_q.size() > 0) begin
      tl.a_valid   = 1'b1;
      tl.a_opcode  = req_q[0].op;
      tl.a_size    = req_q[0].size;
      tl.a_source  = req_q[0].src;
      tl.a_address = req_q[0].addr;
      tl.a_mask    = req_q[0].mask;
      tl.a_data    = req_q[0].data;
    end else begin
      tl.a_valid = 1'b0;
    end
    @(negedge clock);
    s_a_ready = tl.a_ready;
    s_d_valid = tl.d_valid;
    s_mem_en  = mem_en;
    s_fire    = 1'b0;
    if (tl.a_valid && tl.a_ready) begin
      s_fire = 1'b1;
      n_acc++;
      accept(req_q[0]);
      void'(req_q.pop_front());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || req_q.size() != 0) && k < 50) begin
      drive_cycle();
      k++;
    end
    check("drain", exp_q.size() + req_q.size(), 0);
  endtask

  // D-channel monitor: scoreboard pop plus payload stability under stall
  logic        hold_prev = 1'b0;
  logic [42:0] held;
  logic [42:0] payload;
  always @(negedge clock) begin
    payload = {tl.d_opcode, tl.d_size, tl.d_source, tl.d_denied, tl.d_data};
    if (reset_n && tl.d_valid && hold_prev) check("d_stable", payload, held);
    if (reset_n && tl.d_valid && tl.d_ready) begin
      check("beat_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        rsp_t e;
        e = exp_q.pop_front();
        check("d_opcode", tl.d_opcode, e.op);
        check("d_size",   tl.d_size,   e.size);
        check("d_source", tl.d_source, e.src);
        check("d_denied", tl.d_denied, e.denied);
        check("d_data",   tl.d_data,   e.data);
      end
      last_d_data = tl.d_data;
      n_beats++;
    end
    hold_prev = reset_n && tl.d_valid && !tl.d_ready;
    held      = payload;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, b0, dv;
    for (int i = 0; i < int'(WORDS); i++) begin
      sram[i] = 32'hA500_0000 | i;
      mdl[i]  = 32'hA500_0000 | i;
    end
    tl.a_valid = 1'b0; tl.a_opcode = '0; tl.a_size = '0; tl.a_source = '0;
    tl.a_address = '0; tl.a_mask = '0; tl.a_data = '0; tl.d_ready = 1'b1;

    // Reset held with a_valid high
    push_req(3'd4, 3'd2, 4'd0, BASE, 4'hF, 32'h0);
    repeat (3) begin
      drive_cycle();
      check("rst_a_ready", s_a_ready, 1'b0);
      check("rst_d_valid", s_d_valid, 1'b0);
      check("rst_mem_en", s_mem_en, 1'b0);
    end
    check("rst_d_data", tl.d_data, 32'h0);
    check("rst_d_opcode", tl.d_opcode, 3'd0);
    req_q.delete();
    reset_n = 1'b1;
    drive_cycle();
    check("rel_a_ready", s_a_ready, 1'b1);

    // PutFull then Get, with latency check
    push_req(3'd0, 3'd2, 4'd3, 32'h0800_0010, 4'hF, 32'hDEAD_BEEF);
    drive_cycle();
    check("put_fire", s_fire, 1'b1);
    drive_cycle();
    check("lat_n1_d_valid", s_d_valid, 1'b0);
    drive_cycle();
    check("lat_n2_d_valid", s_d_valid, 1'b1);
    push_req(3'd4, 3'd2, 4'd5, 32'h0800_0010, 4'h0, 32'h0);
    drain();
    check("get_deadbeef", last_d_data, 32'hDEAD_BEEF);

    // PutPartial into a known word
    push_req(3'd0, 3'd2, 4'd1, 32'h0800_0020, 4'hF, 32'h1122_3344);
    push_req(3'd1, 3'd0, 4'd2, 32'h0800_0021, 4'h2, 32'h0000_AB00);
    push_req(3'd4, 3'd2, 4'd4, 32'h0800_0020, 4'h0, 32'h0);
    drain();
    check("partial_get", last_d_data, 32'h1122_AB44);

    // Denied and boundary requests
    push_req(3'd4, 3'd2, 4'd6, 32'h0800_4000, 4'hF, 32'h0);  // just past the end
    push_req(3'd2, 3'd2, 4'd7, 32'h0800_0010, 4'hF, 32'h0);  // arithmetic opcode
    push_req(3'd4, 3'd2, 4'd8, 32'h0800_0002, 4'hF, 32'h0);  // misaligned word
    push_req(3'd4, 3'd3, 4'd9, 32'h0800_0000, 4'hF, 32'h0);  // size too large
    push_req(3'd4, 3'd2, 4'hA, 32'h07FF_FFFC, 4'hF, 32'h0);  // just below base
    push_req(3'd0, 3'd2, 4'hB, 32'h0800_3FFC, 4'hF, 32'hCAFE_F00D); // last word
    push_req(3'd4, 3'd1, 4'hC, 32'h0800_3FFE, 4'h0, 32'h0);  // halfword at top
    drain();
    check("last_word_get", last_d_data, 32'hCAFE_F00D);

    // Backpressure: only two requests fit with d_ready low
    tl.d_ready = 1'b0;
    a0 = n_acc;
    push_req(3'd4, 3'd2, 4'd9, 32'h0800_0000, 4'h0, 32'h0);
    push_req(3'd4, 3'd2, 4'd2, 32'h0800_0004, 4'h0, 32'h0);
    push_req(3'd4, 3'd2, 4'd7, 32'h0800_0010, 4'h0, 32'h0);
    push_req(3'd4, 3'd2, 4'd1, 32'h0800_0020, 4'h0, 32'h0);
    repeat (6) drive_cycle();
    check("bp_accepted", n_acc - a0, 2);
    check("bp_a_ready", s_a_ready, 1'b0);
    check("bp_d_valid", s_d_valid, 1'b1);
    tl.d_ready = 1'b1;
    b0 = n_beats;
    repeat (4) begin
      drive_cycle();
      check("bp_restart_d_valid", s_d_valid, 1'b1);
    end
    check("bp_beats", n_beats - b0, 4);
    drain();

    // Sustained throughput
    a0 = n_acc;
    b0 = n_beats;
    for (int i = 0; i < 16; i++)
      push_req(3'd4, 3'd2, 4'(i), BASE + 32'(4 * i), 4'h0, 32'h0);
    repeat (18) drive_cycle();
    check("tp_accepted", n_acc - a0, 16);
    check("tp_beats", n_beats - b0, 16);
    drain();

    // Reset with two queued responses
    tl.d_ready = 1'b0;
    push_req(3'd4, 3'd2, 4'd3, 32'h0800_0008, 4'h0, 32'h0);
    push_req(3'd4, 3'd2, 4'd4, 32'h0800_000C, 4'h0, 32'h0);
    repeat (4) drive_cycle();
    check("mid_full_d_valid", s_d_valid, 1'b1);
    check("mid_full_a_ready", s_a_ready, 1'b0);
    reset_n = 1'b0;
    exp_q.delete();
    req_q.delete();
    drive_cycle();
    check("mid_rst_d_valid", s_d_valid, 1'b0);
    check("mid_rst_a_ready", s_a_ready, 1'b0);
    drive_cycle();
    reset_n = 1'b1;
    tl.d_ready = 1'b1;
    b0 = n_beats;
    dv = 0;
    repeat (5) begin
      drive_cycle();
      if (s_d_valid) dv++;
    end
    check("post_rst_no_beat", dv, 0);
    check("post_rst_beats", n_beats - b0, 0);
    check("post_rst_a_ready", s_a_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
